// File: rtl/keypad_decoder_if.sv
// keypad_decoder_if: keypad pins plus the key valid/ready stream toward the calculator controller
interface keypad_decoder_if;
    logic [6:0] row;
    logic [4:0] col;
    logic       key_ready;
    logic       key_valid;
    logic [5:0] key_code;
    logic       key_overrun;
    logic       any_key;
    modport master (input row, col, key_ready, output key_valid, key_code, key_overrun, any_key);
    modport slave  (output row, col, key_ready, input key_valid, key_code, key_overrun, any_key);
endinterface

// File: rtl/keypad_decoder.sv
// keypad_decoder: debounces the 7x5 active-low keypad and emits one code per press into a 1-entry buffer
module keypad_decoder #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input logic              clock,
    input logic              internal_reset,
    keypad_decoder_if.master kif
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [11:0] IDLE_PAT = '1;

    typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} state_t;

    state_t        state, state_n;
    logic [11:0]   s1, s2, l;
    logic [CW-1:0] cnt;
    logic          done, single, emit;
    logic [2:0]    ri, ci;
    logic [5:0]    code;

    always_ff @(posedge clock) begin
        if (internal_reset) begin
            s1    <= '1;
            s2    <= '1;
            l     <= '1;
            state <= IDLE;
            cnt   <= '0;
        end else begin
            s1    <= {kif.row, kif.col};
            s2    <= s1;
            state <= state_n;
            cnt   <= (state_n != state || state == IDLE || state == HELD) ? '0 : cnt + CW'(1);
            if (state == IDLE) l <= s2;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:        if (s2 != IDLE_PAT) state_n = DEB_PRESS;
            DEB_PRESS:   if (s2 != l) state_n = IDLE; else if (done) state_n = HELD;
            HELD:        if (s2 == IDLE_PAT) state_n = DEB_RELEASE;
            DEB_RELEASE: if (s2 != IDLE_PAT) state_n = HELD; else if (done) state_n = IDLE;
            default:     state_n = IDLE;
        endcase
    end

    always_comb begin
        done        = cnt == CW'(DEBOUNCE_CYCLES - 1);
        single      = $onehot(~l[11:5]) && $onehot(~l[4:0]);
        emit        = state == DEB_PRESS && s2 == l && done && single;
        kif.any_key = state == HELD || state == DEB_RELEASE;
    end

    always_comb begin
        ri = '0;
        ci = '0;
        for (int i = 0; i < 7; i++) if (!l[5+i]) ri = 3'(i);
        for (int i = 0; i < 5; i++) if (!l[i]) ci = 3'(i);
        code = 6'(ri) * 6'd5 + 6'(ci);
    end

    // a new code may replace the pending one only when that one is consumed in the same cycle
    always_ff @(posedge clock) begin
        if (internal_reset) begin
            kif.key_valid   <= 1'b0;
            kif.key_code    <= '0;
            kif.key_overrun <= 1'b0;
        end else if (emit && (!kif.key_valid || kif.key_ready)) begin
            kif.key_valid <= 1'b1;
            kif.key_code  <= code;
        end else begin
            if (emit) kif.key_overrun <= 1'b1;
            if (kif.key_valid && kif.key_ready) kif.key_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_keypad_decoder.sv
// tb_keypad_decoder: directed keypad scenarios with DEBOUNCE_CYCLES=4 and hand-computed expectations
module tb_keypad_decoder;
    logic clk = 0;
    logic rst = 1;
    int   n_cmp = 0, n_err = 0, n_acc = 0, base = 0;
    logic [5:0] last = '0;

    keypad_decoder_if kif ();
    keypad_decoder #(.DEBOUNCE_CYCLES(4)) dut (.clock(clk), .internal_reset(rst), .kif(kif));

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst && kif.key_valid && kif.key_ready) begin
            n_acc <= n_acc + 1;
            last  <= kif.key_code;
        end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set(input logic [6:0] r, input logic [4:0] c);
        @(negedge clk);
        kif.row = r;
        kif.col = c;
    endtask

    task automatic latency13(input string tag);
        for (int k = 1; k <= 7; k++) begin
            cyc(1);
            if (k == 6) chk({tag, "_valid_early"}, kif.key_valid, 0);
            if (k == 7) begin
                chk({tag, "_valid_c7"}, kif.key_valid, 1);
                chk({tag, "_code_c7"}, kif.key_code, 13);
            end
        end
    endtask

    initial begin
        kif.row = '1;
        kif.col = '1;
        kif.key_ready = 1;
        cyc(3);
        chk("rst_valid", kif.key_valid, 0);
        chk("rst_code", kif.key_code, 0);
        chk("rst_ovr", kif.key_overrun, 0);
        chk("rst_any", kif.any_key, 0);
        @(negedge clk) rst = 0;
        cyc(3);

        set(7'b1111011, 5'b10111);
        latency13("t1");
        cyc(13);
        chk("t1_any_held", kif.any_key, 1);
        chk("t1_count", n_acc, 1);
        set('1, '1);
        cyc(6);
        chk("t1_any_rel_deb", kif.any_key, 1);
        cyc(1);
        chk("t1_any_idle", kif.any_key, 0);
        chk("t1_count_after", n_acc, 1);

        base = n_acc;
        repeat (2) begin
            set(7'b1111110, 5'b11110);
            cyc(2);
            set('1, '1);
            cyc(2);
        end
        chk("t2_bounce_none", n_acc, base);
        set(7'b1111110, 5'b11110);
        cyc(20);
        chk("t2_count", n_acc, base + 1);
        chk("t2_code", last, 0);
        set('1, '1);
        cyc(10);

        base = n_acc;
        set(7'b1111110, 5'b11100);
        cyc(20);
        chk("t3_any", kif.any_key, 1);
        chk("t3_valid", kif.key_valid, 0);
        chk("t3_count", n_acc, base);
        set('1, '1);
        cyc(10);
        chk("t3_any_off", kif.any_key, 0);

        kif.key_ready = 0;
        base = n_acc;
        set(7'b0111111, 5'b01111);
        cyc(10);
        chk("t4_code34", kif.key_code, 34);
        set('1, '1);
        cyc(10);
        set(7'b1111101, 5'b11110);
        cyc(10);
        chk("t4_keep34", kif.key_code, 34);
        chk("t4_valid", kif.key_valid, 1);
        chk("t4_ovr", kif.key_overrun, 1);
        @(negedge clk) kif.key_ready = 1;
        cyc(1);
        chk("t4_consumed", kif.key_valid, 0);
        chk("t4_ovr_sticky", kif.key_overrun, 1);
        cyc(1);
        chk("t4_acc_code", last, 34);
        chk("t4_acc_count", n_acc, base + 1);
        set('1, '1);
        cyc(10);
        @(negedge clk) rst = 1;
        cyc(1);
        chk("t4_rst_ovr", kif.key_overrun, 0);
        @(negedge clk) rst = 0;
        cyc(2);

        kif.key_ready = 0;
        base = n_acc;
        set(7'b1111101, 5'b11011);
        cyc(10);
        chk("t5_code7", kif.key_code, 7);
        set('1, '1);
        cyc(10);
        set(7'b1111101, 5'b10111);
        cyc(6);
        chk("t5_pending7", kif.key_code, 7);
        @(negedge clk) kif.key_ready = 1;
        cyc(1);
        chk("t5_valid", kif.key_valid, 1);
        chk("t5_code8", kif.key_code, 8);
        chk("t5_ovr", kif.key_overrun, 0);
        chk("t5_acc7", last, 7);
        cyc(1);
        chk("t5_drain", kif.key_valid, 0);
        chk("t5_acc8", last, 8);
        chk("t5_count", n_acc, base + 2);
        set('1, '1);
        cyc(10);

        kif.key_ready = 0;
        set(7'b1111011, 5'b10111);
        cyc(10);
        chk("t6_pending", kif.key_valid, 1);
        @(negedge clk) rst = 1;
        cyc(1);
        chk("t6_valid", kif.key_valid, 0);
        chk("t6_code", kif.key_code, 0);
        chk("t6_ovr", kif.key_overrun, 0);
        chk("t6_any", kif.any_key, 0);
        @(negedge clk) rst = 0;
        latency13("t6");
        @(negedge clk) kif.key_ready = 1;
        cyc(2);
        chk("t6_consumed", kif.key_valid, 0);
        chk("t6_last", last, 13);
        set('1, '1);
        cyc(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
